// File: rtl/btn_event_pkg.sv
// Shared definitions for the button event generator: channel FSM state
// encoding, counter width, channel count and a parameter range helper.
package btn_event_pkg;

  // Number of independent button channels.
  localparam int NUM_BTN = 4;

  // Width of each channel's hold counter. It is wide enough for a full
  // LONG_CYC or REPEAT_CYC period.
  localparam int CNT_W = 27;

  // Channel FSM states. REPEAT is only entered in builds with auto-repeat.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } btn_state_t;

  // True when a cycle-count parameter is usable by the hold counter:
  // at least 2 cycles and no more than the counter can represent.
  function automatic logic cyc_in_range(input int cyc);
    return (cyc >= 2) && (cyc <= ((1 << CNT_W) - 1));
  endfunction

endpackage

// File: rtl/btn_event_chan.sv
// Single button channel: edge detection, hold counter and the
// IDLE / PRESSED / LONG / REPEAT state machine. All event outputs are
// registered one-cycle pulses, and held_o is a registered level.
// Auto-repeat is built only when macro BTN_REPEAT_EN is defined.
// Without it, the channel stays in LONG until release and repeat_o is 0.
//
// Event timing, where N is the edge that first samples the button high:
//   press_o   high in the cycle right after edge N
//   long_o    LONG_CYC cycles after press_o
//   repeat_o  every REPEAT_CYC cycles after long_o
//   release_o one cycle after the edge that samples the button low
// A release always wins over a long or repeat threshold in the same cycle.
import btn_event_pkg::*;

module btn_event_chan #(
  parameter int LONG_CYC   = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic       repeat_o,
  output logic       held_o,
  output btn_state_t state_o
);

  // Reject parameter values the hold counter cannot represent.
  if (!cyc_in_range(LONG_CYC)) begin : g_bad_long_cyc
    $error("btn_event_chan: LONG_CYC out of range 2..2^27-1");
  end
  if (!cyc_in_range(REPEAT_CYC)) begin : g_bad_repeat_cyc
    $error("btn_event_chan: REPEAT_CYC out of range 2..2^27-1");
  end

  // Terminal counts. The counter is cleared on the threshold edge, so it
  // runs from 0 up to PERIOD-1.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  btn_state_t       state;
  btn_state_t       state_nx;
  logic             btn_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;

  logic rise;
  logic long_hit;
`ifdef BTN_REPEAT_EN
  logic rep_hit;
`endif

  logic press_d;
  logic release_d;
  logic long_d;
  logic repeat_d;
  logic held_d;

  assign rise     = btn_in & ~btn_q;
  assign long_hit = (cnt == LONG_LAST);
`ifdef BTN_REPEAT_EN
  assign rep_hit  = (cnt == REP_LAST);
`endif

  assign state_o = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. A low button always returns to IDLE first.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (rise) state_nx = PRESSED;
      end
      PRESSED: begin
        if (!btn_in)       state_nx = IDLE;
        else if (long_hit) state_nx = LONG;
      end
      LONG: begin
        if (!btn_in)       state_nx = IDLE;
`ifdef BTN_REPEAT_EN
        else if (rep_hit)  state_nx = REPEAT;
`endif
      end
`ifdef BTN_REPEAT_EN
      REPEAT: begin
        if (!btn_in)       state_nx = IDLE;
      end
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Output and counter decode. These values are registered below.
  always_comb begin
    press_d   = (state == IDLE) & rise;
    release_d = (state != IDLE) & ~btn_in;
    long_d    = (state == PRESSED) & btn_in & long_hit;
`ifdef BTN_REPEAT_EN
    repeat_d  = ((state == LONG) | (state == REPEAT)) & btn_in & rep_hit;
`else
    repeat_d  = 1'b0;
`endif
    held_d    = (state_nx != IDLE);

    // The counter restarts on a new press, a release and every threshold
    // hit, so it never wraps.
    if ((state == IDLE) || !btn_in || long_d || repeat_d) begin
      cnt_nx = '0;
`ifdef BTN_REPEAT_EN
    end else begin
      cnt_nx = cnt + CNT_W'(1);
    end
`else
    end else if (state == PRESSED) begin
      cnt_nx = cnt + CNT_W'(1);
    end else begin
      // LONG with no auto-repeat: nothing left to time, so hold at 0.
      cnt_nx = '0;
    end
`endif
  end

  // Button history, hold counter and registered event outputs. The button
  // history tracks the input during reset, so a button held through reset
  // must be released before it can produce a press.
  always_ff @(posedge clk) begin
    btn_q <= btn_in;
    if (rst) begin
      cnt       <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      held_o    <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      press_o   <= press_d;
      release_o <= release_d;
      long_o    <= long_d;
      held_o    <= held_d;
    end
  end

`ifdef BTN_REPEAT_EN
  // Auto-repeat pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_o <= 1'b0;
    end else begin
      repeat_o <= repeat_d;
    end
  end
`else
  assign repeat_o = repeat_d;
`endif

endmodule

// File: rtl/btn_event_gen.sv
// Button event generator: turns NUM_BTN debounced button levels into press,
// release, long-press and auto-repeat pulses plus a held level per button.
// Each button has its own btn_event_chan, and the channels share no logic.
// Auto-repeat is enabled by defining macro BTN_REPEAT_EN.
// dbg_state_o exposes every channel's FSM state: channel i uses bits
// [2*i+1:2*i], encoded as btn_state_t.
import btn_event_pkg::*;

module btn_event_gen #(
  parameter int LONG_CYC   = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_BTN-1:0]   btn_in,
  output logic [NUM_BTN-1:0]   press_o,
  output logic [NUM_BTN-1:0]   release_o,
  output logic [NUM_BTN-1:0]   long_o,
  output logic [NUM_BTN-1:0]   repeat_o,
  output logic [NUM_BTN-1:0]   held_o,
  output logic [2*NUM_BTN-1:0] dbg_state_o
);

  // One independent channel per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_state_t chan_state;

    btn_event_chan #(
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in[i]),
      .press_o   (press_o[i]),
      .release_o (release_o[i]),
      .long_o    (long_o[i]),
      .repeat_o  (repeat_o[i]),
      .held_o    (held_o[i]),
      .state_o   (chan_state)
    );

    assign dbg_state_o[2*i +: 2] = chan_state;
  end

endmodule

// File: tb/tb_btn_event_gen.sv
// Bench for btn_event_gen with LONG_CYC=10 and REPEAT_CYC=4.
// Numbering: "edge e" is the e-th rising clock edge, and "cycle c" is the
// clock period that follows edge c-1. A level sampled at edge e therefore
// shows up on a registered output in cycle e+1.
// Each expected pulse is queued as {cycle, kind, channel}. The monitor
// compares every observed pulse with the head of the queue.
// Kinds: 0=press 1=release 2=long 3=repeat.
module tb_btn_event_gen;

  localparam int LONG_CYC   = 10;
  localparam int REPEAT_CYC = 4;
  localparam int W          = 20;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] press_o;
  logic [3:0] release_o;
  logic [3:0] long_o;
  logic [3:0] repeat_o;
  logic [3:0] held_o;
  logic [7:0] dbg_state_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [W-1:0] exp_q[$];

  btn_event_gen #(
    .LONG_CYC   (LONG_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .press_o     (press_o),
    .release_o   (release_o),
    .long_o      (long_o),
    .repeat_o    (repeat_o),
    .held_o      (held_o),
    .dbg_state_o (dbg_state_o)
  );

  // Clock generation and edge counting.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Driver tasks. Each one returns at a falling edge.
  // Sets the inputs that will be sampled at rising edge e.
  task automatic drive_at(input int e, input logic [3:0] v, input logic r);
    while (cyc < e - 1) @(negedge clk);
    btn_in = v;
    rst    = r;
  endtask

  // Waits until the middle of cycle c.
  task automatic wait_cycle(input int c);
    while (cyc < c - 1) @(negedge clk);
  endtask

  // Queues one expected event.
  task automatic push_ev(input int c, input int k, input int ch);
    logic [W-1:0] w;
    w = {c[15:0], k[1:0], ch[1:0]};
    exp_q.push_back(w);
  endtask

  // Checks held_o in cycle c.
  task automatic check_held(input int c, input logic [3:0] exp, input string nm);
    wait_cycle(c);
    checks++;
    if (held_o !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d held_o=%b expected=%b", nm, c, held_o, exp);
    end
  endtask

  // Checks that every output is 0 in cycle c.
  task automatic check_quiet(input int c, input string nm);
    wait_cycle(c);
    checks++;
    if ({press_o, release_o, long_o, repeat_o, held_o} !== 20'd0) begin
      failures++;
      $display("FAIL %s cycle=%0d press=%b release=%b long=%b repeat=%b held=%b expected all 0",
               nm, c, press_o, release_o, long_o, repeat_o, held_o);
    end
  endtask

  // Scoreboard monitor.
  int           mon_cyc;
  logic         mon_hit;
  logic [W-1:0] mon_ev;
  logic [W-1:0] mon_head;

  always @(negedge clk) begin
    mon_cyc = cyc + 1;
    // Any queued event older than this cycle never appeared.
    while (exp_q.size() > 0 && int'(exp_q[0][19:4]) < mon_cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_event cycle=%0d kind=%0d chan=%0d observed=none",
               exp_q[0][19:4], exp_q[0][3:2], exp_q[0][1:0]);
      void'(exp_q.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        case (k)
          0:       mon_hit = press_o[c];
          1:       mon_hit = release_o[c];
          2:       mon_hit = long_o[c];
          default: mon_hit = repeat_o[c];
        endcase
        if (mon_hit === 1'b1) begin
          mon_ev = {mon_cyc[15:0], k[1:0], c[1:0]};
          checks++;
          if (exp_q.size() > 0 && exp_q[0] == mon_ev) begin
            void'(exp_q.pop_front());
          end else begin
            mon_head = (exp_q.size() > 0) ? exp_q[0] : '1;
            failures++;
            $display("FAIL unexpected_event cycle=%0d kind=%0d chan=%0d expected_next cycle=%0d kind=%0d chan=%0d",
                     mon_cyc, k, c, mon_head[19:4], mon_head[3:2], mon_head[1:0]);
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios with hand-computed event cycles.
  int b;

  initial begin
    rst    = 1'b1;
    btn_in = 4'b0000;
    @(negedge clk);
    check_quiet(3, "reset_outputs");
    drive_at(4, 4'b0000, 1'b0);
    wait_cycle(8);

    // Long hold of button 0: press, long, repeats every 4 cycles, release.
    b = cyc;
    push_ev(b + 6, 0, 0);
    push_ev(b + 16, 2, 0);
`ifdef BTN_REPEAT_EN
    for (int t = 20; t <= 40; t += 4) push_ev(b + t, 3, 0);
`endif
    push_ev(b + 41, 1, 0);
    exp_q.sort();
    drive_at(b + 5, 4'b0001, 1'b0);
    check_held(b + 6, 4'b0001, "hold_held_start");
    check_held(b + 30, 4'b0001, "hold_held_mid");
    drive_at(b + 40, 4'b0000, 1'b0);
    check_held(b + 40, 4'b0001, "hold_held_end");
    check_held(b + 41, 4'b0000, "hold_held_released");
    wait_cycle(b + 48);

    // Short press of button 1: no long pulse.
    b = cyc;
    push_ev(b + 6, 0, 1);
    push_ev(b + 8, 1, 1);
    exp_q.sort();
    drive_at(b + 5, 4'b0010, 1'b0);
    drive_at(b + 7, 4'b0000, 1'b0);
    check_held(b + 8, 4'b0000, "short_held_off");
    wait_cycle(b + 14);

    // Single-edge press of button 1.
    b = cyc;
    push_ev(b + 6, 0, 1);
    push_ev(b + 7, 1, 1);
    exp_q.sort();
    drive_at(b + 5, 4'b0010, 1'b0);
    drive_at(b + 6, 4'b0000, 1'b0);
    wait_cycle(b + 12);

    // Release on the long threshold edge: release wins.
    b = cyc;
    push_ev(b + 6, 0, 0);
    push_ev(b + 16, 1, 0);
    exp_q.sort();
    drive_at(b + 5, 4'b0001, 1'b0);
    drive_at(b + 15, 4'b0000, 1'b0);
    wait_cycle(b + 22);

    // Release on the first repeat threshold edge: release wins.
    b = cyc;
    push_ev(b + 6, 0, 0);
    push_ev(b + 16, 2, 0);
    push_ev(b + 20, 1, 0);
    exp_q.sort();
    drive_at(b + 5, 4'b0001, 1'b0);
    drive_at(b + 19, 4'b0000, 1'b0);
    wait_cycle(b + 26);

    // Reset mid-hold with all buttons held, then a release and re-press.
    b = cyc;
    push_ev(b + 6, 0, 2);
    push_ev(b + 17, 0, 0);
    push_ev(b + 19, 1, 0);
    exp_q.sort();
    drive_at(b + 5, 4'b0100, 1'b0);
    drive_at(b + 8, 4'b1111, 1'b1);
    check_quiet(b + 9, "reset_mid_hold_quiet");
    check_quiet(b + 10, "reset_held_quiet");
    drive_at(b + 11, 4'b1111, 1'b0);
    check_held(b + 13, 4'b0000, "after_reset_no_held");
    drive_at(b + 14, 4'b1110, 1'b0);
    drive_at(b + 16, 4'b1111, 1'b0);
    check_held(b + 17, 4'b0001, "repress_held");
    drive_at(b + 18, 4'b1110, 1'b0);
    drive_at(b + 20, 4'b0000, 1'b0);
    wait_cycle(b + 26);

    // Buttons 2 and 3 pressed 3 cycles apart.
    b = cyc;
    push_ev(b + 6, 0, 2);
    push_ev(b + 9, 0, 3);
    push_ev(b + 16, 2, 2);
    push_ev(b + 19, 2, 3);
`ifdef BTN_REPEAT_EN
    push_ev(b + 20, 3, 2);
    push_ev(b + 23, 3, 3);
    push_ev(b + 24, 3, 2);
    push_ev(b + 27, 3, 3);
`endif
    push_ev(b + 26, 1, 2);
    push_ev(b + 29, 1, 3);
    exp_q.sort();
    drive_at(b + 5, 4'b0100, 1'b0);
    drive_at(b + 8, 4'b1100, 1'b0);
    check_held(b + 12, 4'b1100, "stagger_held_both");
    drive_at(b + 25, 4'b1000, 1'b0);
    check_held(b + 26, 4'b1000, "stagger_held_one");
    drive_at(b + 28, 4'b0000, 1'b0);
    wait_cycle(b + 36);

    // Every queued event must have been seen by now.
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_events remaining=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
